// File: rtl/spart_bus_ctrl.sv
// SPART processor-side controller: bus register decode, rx/tx handshakes and the
// programmable 16x baud-rate tick generator.
module spart_bus_ctrl #(
   parameter logic [15:0] DEFAULT_DIV = 16'd162
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   input  logic [7:0] databus_in,
   output logic [7:0] databus_out,
   output logic       databus_oe,
   input  logic       rda,
   input  logic [7:0] rx_data,
   output logic       clr_rda,
   input  logic       tbr,
   output logic [7:0] tx_data,
   output logic       tx_load,
   output logic       brg_en
);

   typedef enum logic [0:0] {StIdle, StHold} state_e;

   state_e      state_q, state_d;
   logic [7:0]  dout_q, dout_d;
   logic        oe_q, oe_d;
   logic        clr_q, clr_d;
   logic [7:0]  txd_q, txd_d;
   logic        ld_q, ld_d;
   logic        brg_q, brg_d;
   logic        ovf_q, ovf_d;
   logic [7:0]  shadow_q, shadow_d;
   logic [15:0] div_q, div_d;
   logic [15:0] cnt_q, cnt_d;
   logic        div_wr;

   // Bus FSM: one action per iocs assertion, taken on the IDLE->HOLD edge.
   always_comb begin
      state_d  = state_q;
      dout_d   = dout_q;
      oe_d     = 1'b0;
      clr_d    = 1'b0;
      txd_d    = txd_q;
      ld_d     = 1'b0;
      ovf_d    = ovf_q;
      shadow_d = shadow_q;
      div_d    = div_q;
      div_wr   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (iocs) begin
               state_d = StHold;
               oe_d    = iorw;
               if (iorw) begin
                  unique case (ioaddr)
                     2'b00: begin
                        dout_d = rx_data;
                        clr_d  = rda;
                     end
                     2'b01: begin
                        dout_d = {5'b0, ovf_q, tbr, rda};
                        ovf_d  = 1'b0;
                     end
                     2'b10: dout_d = div_q[7:0];
                     2'b11: dout_d = div_q[15:8];
                  endcase
               end else begin
                  unique case (ioaddr)
                     2'b00: begin
                        if (tbr) begin
                           txd_d = databus_in;
                           ld_d  = 1'b1;
                        end else begin
                           ovf_d = 1'b1;
                        end
                     end
                     2'b01: ;
                     2'b10: shadow_d = databus_in;
                     2'b11: begin
                        div_d  = {databus_in, shadow_q};
                        div_wr = 1'b1;
                     end
                  endcase
               end
            end
         end
         StHold: begin
            if (iocs) begin
               oe_d = oe_q;
            end else begin
               state_d = StIdle;
            end
         end
      endcase
   end

   // Baud generator; a divisor-high write overrides a coincident terminal count.
   always_comb begin
      brg_d = 1'b0;
      cnt_d = cnt_q;
      if (div_wr) begin
         cnt_d = div_d;
      end else if (div_q == 16'd0) begin
         cnt_d = 16'd0;
      end else if (cnt_q == 16'd0) begin
         brg_d = 1'b1;
         cnt_d = div_q;
      end else begin
         cnt_d = cnt_q - 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         dout_q   <= 8'h00;
         oe_q     <= 1'b0;
         clr_q    <= 1'b0;
         txd_q    <= 8'h00;
         ld_q     <= 1'b0;
         brg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         shadow_q <= 8'h00;
         div_q    <= DEFAULT_DIV;
         cnt_q    <= DEFAULT_DIV;
      end else begin
         state_q  <= state_d;
         dout_q   <= dout_d;
         oe_q     <= oe_d;
         clr_q    <= clr_d;
         txd_q    <= txd_d;
         ld_q     <= ld_d;
         brg_q    <= brg_d;
         ovf_q    <= ovf_d;
         shadow_q <= shadow_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
      end
   end

   assign databus_out = dout_q;
   assign databus_oe  = oe_q;
   assign clr_rda     = clr_q;
   assign tx_data     = txd_q;
   assign tx_load     = ld_q;
   assign brg_en      = brg_q;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Directed self-checking bench for spart_bus_ctrl.
module tb_spart_bus_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       iocs = 1'b0;
   logic       iorw = 1'b0;
   logic [1:0] ioaddr = 2'b00;
   logic [7:0] databus_in = 8'h00;
   logic [7:0] databus_out;
   logic       databus_oe;
   logic       rda = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       clr_rda;
   logic       tbr = 1'b0;
   logic [7:0] tx_data;
   logic       tx_load;
   logic       brg_en;

   int checks = 0;
   int failures = 0;

   spart_bus_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .iocs        (iocs),
      .iorw        (iorw),
      .ioaddr      (ioaddr),
      .databus_in  (databus_in),
      .databus_out (databus_out),
      .databus_oe  (databus_oe),
      .rda         (rda),
      .rx_data     (rx_data),
      .clr_rda     (clr_rda),
      .tbr         (tbr),
      .tx_data     (tx_data),
      .tx_load     (tx_load),
      .brg_en      (brg_en)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Edges until brg_en is seen high after an edge; -1 when the budget runs out.
   task automatic wait_tick(input int max, output int n);
      n = -1;
      for (int i = 1; i <= max; i++) begin
         @(posedge clk);
         #1;
         if (brg_en) begin
            n = i;
            break;
         end
      end
   endtask

   // Holds iocs for n edges, then releases it and watches three more edges.
   task automatic bus_xfer(input logic rw, input logic [1:0] addr, input logic [7:0] din,
                           input int n, output logic [7:0] dout, output int oe_cnt,
                           output int clr_cnt, output int ld_cnt);
      oe_cnt = 0;
      clr_cnt = 0;
      ld_cnt = 0;
      dout = 8'h00;
      iocs = 1'b1;
      iorw = rw;
      ioaddr = addr;
      databus_in = din;
      for (int i = 0; i < n + 3; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) dout = databus_out;
         if (i == n - 1) iocs = 1'b0;
         oe_cnt += int'(databus_oe);
         clr_cnt += int'(clr_rda);
         ld_cnt += int'(tx_load);
      end
   endtask

   logic [7:0] d;
   int oe_c, clr_c, ld_c, n;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_outputs", {databus_out, databus_oe, clr_rda, tx_data, tx_load, brg_en},
                32'h0);
      rst = 1'b1;

      wait_tick(400, n);
      check_val("brg_first_163", n, 163);
      wait_tick(400, n);
      check_val("brg_period_163", n, 163);

      bus_xfer(1'b0, 2'b10, 8'h04, 1, d, oe_c, clr_c, ld_c);
      bus_xfer(1'b1, 2'b10, 8'h00, 1, d, oe_c, clr_c, ld_c);
      check_val("div_lo_old", d, 8'hA2);
      bus_xfer(1'b1, 2'b11, 8'h00, 1, d, oe_c, clr_c, ld_c);
      check_val("div_hi_old", d, 8'h00);

      iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b11; databus_in = 8'h00;
      @(posedge clk);
      #1;
      iocs = 1'b0;
      wait_tick(50, n);
      check_val("brg_first_after_wr", n, 5);
      wait_tick(50, n);
      check_val("brg_period_5", n, 5);
      bus_xfer(1'b1, 2'b10, 8'h00, 1, d, oe_c, clr_c, ld_c);
      check_val("div_lo_new", d, 8'h04);

      rda = 1'b1; rx_data = 8'h5A;
      bus_xfer(1'b1, 2'b00, 8'h00, 4, d, oe_c, clr_c, ld_c);
      check_val("rx_data", d, 8'h5A);
      check_val("rx_oe_cycles", oe_c, 4);
      check_val("rx_clr_once", clr_c, 1);

      rda = 1'b0; tbr = 1'b0;
      bus_xfer(1'b0, 2'b00, 8'h41, 1, d, oe_c, clr_c, ld_c);
      check_val("ovf_no_load", ld_c, 0);
      check_val("ovf_txdata_kept", tx_data, 8'h00);
      check_val("wr_no_oe", oe_c, 0);
      bus_xfer(1'b1, 2'b01, 8'h00, 1, d, oe_c, clr_c, ld_c);
      check_val("status_ovf", d, 8'h04);
      check_val("status_oe_1cyc", oe_c, 1);
      bus_xfer(1'b1, 2'b01, 8'h00, 1, d, oe_c, clr_c, ld_c);
      check_val("status_cleared", d, 8'h00);
      rda = 1'b0; rx_data = 8'h77;
      bus_xfer(1'b1, 2'b00, 8'h00, 1, d, oe_c, clr_c, ld_c);
      check_val("rx_no_rda_data", d, 8'h77);
      check_val("rx_no_rda_clr", clr_c, 0);

      tbr = 1'b1;
      bus_xfer(1'b0, 2'b00, 8'h33, 2, d, oe_c, clr_c, ld_c);
      check_val("tx_data", tx_data, 8'h33);
      check_val("tx_load_once", ld_c, 1);
      rda = 1'b1;
      bus_xfer(1'b1, 2'b01, 8'h00, 1, d, oe_c, clr_c, ld_c);
      check_val("status_tbr_rda", d, 8'h03);

      bus_xfer(1'b0, 2'b10, 8'h00, 1, d, oe_c, clr_c, ld_c);
      bus_xfer(1'b0, 2'b11, 8'h00, 1, d, oe_c, clr_c, ld_c);
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1;
         n += int'(brg_en);
      end
      check_val("div0_no_tick", n, 0);

      // Divisor 4 at edge N; a second high write lands on edge N+5 where the count hits 0.
      bus_xfer(1'b0, 2'b10, 8'h04, 1, d, oe_c, clr_c, ld_c);
      iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b11; databus_in = 8'h00;
      @(posedge clk);
      #1;
      iocs = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      iocs = 1'b1;
      @(posedge clk);
      #1;
      iocs = 1'b0;
      check_val("coinc_no_tick", brg_en, 1'b0);
      wait_tick(50, n);
      check_val("coinc_reload", n, 5);

      rda = 1'b1; rx_data = 8'hC3;
      iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check_val("hold_oe_before_rst", databus_oe, 1'b1);
      rst = 1'b0;
      #1;
      check_val("rst_async_outputs", {databus_out, databus_oe, clr_rda, tx_data, tx_load},
                32'h0);
      iocs = 1'b0;
      @(posedge clk);
      #1;
      check_val("rst_held_no_clr", clr_rda, 1'b0);
      rst = 1'b1;
      bus_xfer(1'b1, 2'b10, 8'h00, 1, d, oe_c, clr_c, ld_c);
      check_val("rst_div_default", d, 8'hA2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spart_bus_ctrl.md
# spart_bus_ctrl

Processor-side controller for the SPART: decodes the 2-bit I/O register space and sequences the receiver (hands off received bytes, issues `clr_rda`) and transmitter (`tx_load` strobe). It also owns the programmable baud-rate generator that produces the 16x-oversampling `brg_en` tick the receiver samples on. It sits between the processor bus and the receiver/transmitter pair inside the SPART top.

## Interface
- `DEFAULT_DIV`, 16'd162: divisor after reset; `brg_en` period = divisor+1 clocks (≈16x38400 at 100 MHz).
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `iocs`  in  1  chip select; high = bus access requested.
- `iorw`  in  1  1 = read, 0 = write.
- `ioaddr`  in  2  00 rx/tx buffer, 01 status, 10 divisor low, 11 divisor high.
- `databus_in`  in  8  write data.
- `databus_out`  out  8  read data (registered).
- `databus_oe`  out  1  drive enable for `databus_out`.
- `rda`  in  1  receiver byte ready.
- `rx_data`  in  8  receiver byte.
- `clr_rda`  out  1  one-cycle pulse: byte consumed.
- `tbr`  in  1  transmitter buffer ready.
- `tx_data`  out  8  byte to transmitter (registered).
- `tx_load`  out  1  one-cycle pulse: load `tx_data`.
- `brg_en`  out  1  one-cycle baud tick.

## Operation
- Bus FSM, states IDLE, HOLD. IDLE & `iocs`=1 at an edge: access accepted (acts on `iorw`/`ioaddr`/`databus_in` sampled that edge), go HOLD. HOLD: stay while `iocs`=1; `iocs`=0 -> IDLE. One action per `iocs` assertion regardless of length.
- Read accept: `databus_out` latched with selected value; `databus_oe`=1 throughout HOLD when accepted access was a read, else 0.
  - 00: `rx_data`; if `rda`=1, `clr_rda` pulses; if `rda`=0, data returned, no pulse.
  - 01: {5'b0, tx_ovf, `tbr`, `rda`}; then tx_ovf cleared (read returns pre-clear value).
  - 10 / 11: current divisor[7:0] / divisor[15:8] (not shadow).
- Write accept:
  - 00: `tbr`=1 -> `tx_data`<=`databus_in`, `tx_load` pulses. `tbr`=0 -> write dropped, `tx_data` unchanged, tx_ovf<=1 (sticky).
  - 01: no effect.
  - 10: shadow_low<=`databus_in`; divisor unchanged.
  - 11: divisor<={`databus_in`, shadow_low}; baud counter reloaded with same value.
- Baud generator: 16-bit down counter. Count==0 and divisor!=0: `brg_en`=1, counter<=divisor; else counter decrements. Divisor==0: `brg_en` held 0, counter held 0.
- Divisor-high write same cycle counter hits 0: write wins, counter loads new divisor, no `brg_en` that cycle.

## Timing
- Reset values: `databus_out`=0, `databus_oe`=0, `clr_rda`=0, `tx_data`=0, `tx_load`=0, `brg_en`=0; divisor=counter=`DEFAULT_DIV`, shadow_low=0, tx_ovf=0, FSM IDLE.
- Access accepted at edge N: `databus_out`, `databus_oe`, `clr_rda`, `tx_load`, `tx_data` valid after edge N (one-cycle latency); pulses deassert after edge N+1.
- `clr_rda`/`tx_load` high exactly one cycle per accepted access, never during HOLD repeat.
- First `brg_en` after reset: after DEFAULT_DIV+1 edges; then every divisor+1 cycles. After divisor-high write at edge N, first tick at edge N+divisor+1.
- `rst` low mid-access or mid-count: all state to reset values immediately; no pulse emitted; bus access in progress is lost.
- `iocs` low at edge N+1 after accept: HOLD lasts one cycle, `databus_oe` one cycle.

## Test plan
- Reset, divisor default 162 -> `brg_en` pulses every 163 clocks, first at clock 163; all outputs 0 during reset.
- Write 10<=8'h04, 11<=8'h00 -> `brg_en` every 5 clocks from the write; read 10 before high write returns 8'hA2 (old).
- `rda`=1, `rx_data`=8'h5A, read 00 with `iocs` held 4 cycles -> `databus_out`=8'h5A, `databus_oe` high 4 cycles, single `clr_rda` pulse.
- `tbr`=0, write 00<=8'h41 -> no `tx_load`; status read returns 8'h04 (with `rda`=0); second status read returns 8'h00.
- `tbr`=1, write 00<=8'h33 -> `tx_data`=8'h33, one `tx_load` pulse; divisor 0 written -> `brg_en` stays 0 for 1000 clocks.
- Divisor-high write coinciding with counter==0 -> no tick that cycle; `rst` asserted mid-HOLD -> `databus_oe` drops immediately, no `clr_rda`.
